// File: rtl/bexkat1_pkg.sv
// Shared definitions for the bexkat1 fetch and decode path.
package bexkat1_pkg;
  localparam logic [63:0] NOP_IR           = 64'h0;
  localparam int          LONG_BIT_DEFAULT = 0;
endpackage

// File: rtl/ifq_fifo.sv
// Prefetch word queue: circular buffer with an occupancy count, up to two pops
// per cycle, and combinational peek of the two head entries.
module ifq_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [31:0]               push_data_i,
  input  logic                      pop1_i,
  input  logic                      pop2_i,
  output logic [31:0]               h0_o,
  output logic [31:0]               h1_o,
  output logic [$clog2(DEPTH):0]    count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_nxt;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pop_n;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pop_n    = pop2_i ? CW'(2) : (pop1_i ? CW'(1) : '0);
    rd_nxt   = rd_ptr_q + PW'(1);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      // Pointer width equals log2(DEPTH), so the truncating add wraps modulo DEPTH.
      rd_ptr_d = rd_ptr_q + PW'(pop_n);
      count_d  = count_q + CW'(push_i) - pop_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign h0_o    = mem_q[rd_ptr_q];
  assign h1_o    = mem_q[rd_nxt];
  assign count_o = count_q;
endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: prefetches words over a classic bus into a small
// queue and assembles one- or two-word instructions for decode.
module ifetch_queue
  import bexkat1_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 4,
  parameter int          LONG_BIT = LONG_BIT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        pc_set_i,
  input  logic [31:0] pc_in,
  output logic        bus_cyc,
  output logic [31:0] bus_adr,
  input  logic        bus_ack,
  input  logic [31:0] bus_in,
  output logic [63:0] ir,
  output logic [31:0] pc,
  output logic        valid
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_adr_q, fetch_adr_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic [31:0]   pc_q, pc_d;
  logic [63:0]   ir_q, ir_d;
  logic          valid_q, valid_d;
  logic [31:0]   h0, h1;
  logic [CW-1:0] count;
  logic          push, pop1, pop2, is_long, complete;

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (pc_set_i),
    .push_i      (push),
    .push_data_i (bus_in),
    .pop1_i      (pop1),
    .pop2_i      (pop2),
    .h0_o        (h0),
    .h1_o        (h1),
    .count_o     (count)
  );

  always_comb begin
    // Holding cyc low while full keeps a push from ever landing on a full queue.
    bus_cyc     = !rst_i && !pc_set_i && (count < CW'(DEPTH));
    push        = bus_cyc && bus_ack;
    is_long     = h0[LONG_BIT];
    complete    = is_long ? (count >= CW'(2)) : (count != '0);
    pop1        = 1'b0;
    pop2        = 1'b0;
    fetch_adr_d = push ? fetch_adr_q + 32'd4 : fetch_adr_q;
    head_pc_d   = head_pc_q;
    ir_d        = ir_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    if (pc_set_i) begin
      fetch_adr_d = pc_in;
      head_pc_d   = pc_in;
      ir_d        = NOP_IR;
      valid_d     = 1'b0;
    end else if (!stall_i) begin
      if (complete) begin
        pop1      = !is_long;
        pop2      = is_long;
        ir_d      = {h0, (is_long ? h1 : 32'h0)};
        pc_d      = head_pc_q;
        valid_d   = 1'b1;
        head_pc_d = head_pc_q + (is_long ? 32'd8 : 32'd4);
      end else begin
        ir_d    = NOP_IR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_adr_q <= RESET_PC;
      head_pc_q   <= RESET_PC;
      ir_q        <= NOP_IR;
      pc_q        <= 32'h0;
      valid_q     <= 1'b0;
    end else begin
      fetch_adr_q <= fetch_adr_d;
      head_pc_q   <= head_pc_d;
      ir_q        <= ir_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
    end
  end

  assign bus_adr = fetch_adr_q;
  assign ir      = ir_q;
  assign pc      = pc_q;
  assign valid   = valid_q;
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue at depths 4, 2 and 8 sharing one stimulus stream; each
// copy has its own bus responder and an in-order instruction scoreboard.
module tb_ifetch_queue;
  logic        clk      = 1'b0;
  logic        rst_i    = 1'b1;
  logic        stall_i  = 1'b0;
  logic        pc_set_i = 1'b0;
  logic [31:0] pc_in    = 32'h0;

  int          total     = 0;
  int          bad       = 0;
  int          max_delay = 0;
  logic        ack_block = 1'b0;
  logic        force_ack = 1'b0;
  logic        done      = 1'b0;
  int          seg_id    = 0;
  logic [31:0] seg_pc    = 32'h0;

  // Inputs as seen by the most recent rising edge.
  logic e_rst = 1'b1, e_set = 1'b0, e_stall = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    e_rst   = rst_i;
    e_set   = pc_set_i;
    e_stall = stall_i;
  end

  // ---------------- memory image and checker ----------------
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'h0000_0000: return 32'h1000_0000;
      32'h0000_0004: return 32'h2000_0001;
      32'h0000_0008: return 32'hDEAD_BEEF;
      32'h0000_000C: return 32'h3000_0000;
      32'h0000_0100: return 32'h4000_0000;
      default: begin
        h = (a ^ 32'h1234_5678) * 32'h9E37_79B1;
        return h ^ (h >> 15);
      end
    endcase
  endfunction

  task automatic chk(input string name, input int inst, input logic [127:0] act,
                     input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h want=%h", name, inst, act, req);
    end
  endtask

  // ---------------- DUT copies, bus responders, monitors ----------------
  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int D = (g == 0) ? 4 : ((g == 1) ? 2 : 8);

    logic        bus_cyc, valid;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_adr, pc;
    logic [31:0] bus_in = 32'h0;
    logic [63:0] ir;

    logic [95:0] exp_q[$];
    int          seen_seg  = -1;
    int          n_out     = 0;
    int          wait_left = 0;
    logic        pending   = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc = 32'h0, last_pc = 32'h0;
    logic [63:0] prev_ir = 64'h0;
    logic [31:0] ma, w0, w1;
    logic [95:0] e;

    ifetch_queue #(.RESET_PC(32'h0), .DEPTH(D), .LONG_BIT(0)) dut (
      .clk_i    (clk),
      .rst_i    (rst_i),
      .stall_i  (stall_i),
      .pc_set_i (pc_set_i),
      .pc_in    (pc_in),
      .bus_cyc  (bus_cyc),
      .bus_adr  (bus_adr),
      .bus_ack  (bus_ack),
      .bus_in   (bus_in),
      .ir       (ir),
      .pc       (pc),
      .valid    (valid)
    );

    // Bus responder: random wait states; stray acks while cyc is low.
    always @(posedge clk) begin
      #2;
      if (bus_cyc) begin
        if (!pending) begin
          pending   = 1'b1;
          wait_left = $urandom_range(0, max_delay);
        end else if (wait_left > 0) begin
          wait_left--;
        end
        bus_ack = (wait_left == 0) && !ack_block;
        bus_in  = ram_word(bus_adr);
        if (bus_ack) pending = 1'b0;
      end else begin
        pending = 1'b0;
        bus_ack = force_ack || ($urandom_range(0, 3) == 0);
        bus_in  = $urandom();
      end
    end

    // Monitor: refill expectations on a new fetch stream, then check outputs.
    always @(negedge clk) begin
      if (seg_id != seen_seg) begin
        seen_seg = seg_id;
        exp_q.delete();
        ma = seg_pc;
        repeat (100) begin
          w0 = ram_word(ma);
          if (w0[0]) begin
            w1 = ram_word(ma + 32'd4);
            exp_q.push_back({ma, w0, w1});
            ma = ma + 32'd8;
          end else begin
            exp_q.push_back({ma, w0, 32'h0});
            ma = ma + 32'd4;
          end
        end
      end
      if (e_rst || e_set) begin
        if (e_rst) last_pc = 32'h0;
        chk("flush", g, 128'({valid, pc, ir}), 128'({1'b0, last_pc, 64'h0}));
      end else if (e_stall) begin
        chk("hold", g, 128'({valid, pc, ir}), 128'({prev_valid, prev_pc, prev_ir}));
      end else if (valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL underrun inst=%0d got_pc=%h", g, pc);
        end else begin
          e = exp_q.pop_front();
          chk("instr", g, 128'({pc, ir}), 128'(e));
          n_out++;
        end
        last_pc = pc;
      end else begin
        chk("bubble", g, 128'({pc, ir}), 128'({last_pc, 64'h0}));
      end
      prev_valid = valid;
      prev_pc    = pc;
      prev_ir    = ir;
    end

    initial begin
      wait (done);
      chk("progress", g, 128'(n_out >= 100), 128'd1);
    end
  end

  // ---------------- driver ----------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus", 0, 128'({g_inst[0].bus_cyc, g_inst[0].bus_adr}), 128'({1'b0, 32'h0}));
    chk("rst_out", 0, 128'({g_inst[0].valid, g_inst[0].pc, g_inst[0].ir}), 128'(0));

    @(posedge clk); #1;
    rst_i = 1'b0; seg_id++; seg_pc = 32'h0;
    @(negedge clk);  // cycle 1
    chk("cyc_rise", 0, 128'({g_inst[0].bus_cyc, g_inst[0].bus_adr}), 128'({1'b1, 32'h0}));
    @(negedge clk);  // cycle 2
    @(negedge clk);  // cycle 3
    chk("first_ir", 0, 128'({g_inst[0].valid, g_inst[0].pc, g_inst[0].ir}),
        128'({1'b1, 32'h0, 64'h1000_0000_0000_0000}));
    @(negedge clk);
    chk("no_split", 0, 128'({g_inst[0].valid, g_inst[0].ir}), 128'(0));
    @(negedge clk);
    chk("long_ir", 0, 128'({g_inst[0].valid, g_inst[0].pc, g_inst[0].ir}),
        128'({1'b1, 32'h4, 64'h2000_0001_DEAD_BEEF}));
    @(negedge clk);
    chk("after_long", 0, 128'({g_inst[0].valid, g_inst[0].pc, g_inst[0].ir}),
        128'({1'b1, 32'hC, 64'h3000_0000_0000_0000}));

    // Stall for 10 cycles while the queue fills.
    #1 stall_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold", 0, 128'({g_inst[0].valid, g_inst[0].pc, g_inst[0].ir}),
          128'({1'b1, 32'hC, 64'h3000_0000_0000_0000}));
    end
    chk("full_cyc", 0, 128'(g_inst[0].bus_cyc), 128'(0));

    // Redirect while stalled with a full queue.
    @(posedge clk); #1;
    pc_set_i = 1'b1; pc_in = 32'h200;
    @(negedge clk);
    chk("set_cyc_a", 0, 128'(g_inst[0].bus_cyc), 128'(0));
    @(posedge clk); #1;
    pc_set_i = 1'b0; stall_i = 1'b0; seg_id++; seg_pc = 32'h200;
    @(negedge clk);
    chk("flush_win", 0, 128'({g_inst[0].valid, g_inst[0].ir}), 128'(0));
    chk("redir_a", 0, 128'({g_inst[0].bus_cyc, g_inst[0].bus_adr}), 128'({1'b1, 32'h200}));

    // Redirect with a request outstanding and a stray ack in the redirect cycle.
    repeat (5) @(posedge clk);
    #1 ack_block = 1'b1;
    @(negedge clk);
    chk("outstanding", 0, 128'(g_inst[0].bus_cyc), 128'(1));
    @(posedge clk); #1;
    pc_set_i = 1'b1; pc_in = 32'h100; force_ack = 1'b1; ack_block = 1'b0;
    @(negedge clk);
    chk("set_cyc_b", 0, 128'(g_inst[0].bus_cyc), 128'(0));
    @(posedge clk); #1;
    pc_set_i = 1'b0; force_ack = 1'b0; seg_id++; seg_pc = 32'h100;
    @(negedge clk);
    chk("redir_b", 0, 128'({g_inst[0].bus_cyc, g_inst[0].bus_adr, g_inst[0].valid}),
        128'({1'b1, 32'h100, 1'b0}));
    @(negedge clk);
    chk("redir_lat", 0, 128'(g_inst[0].valid), 128'(0));
    @(negedge clk);
    chk("redir_ir", 0, 128'({g_inst[0].valid, g_inst[0].pc, g_inst[0].ir}),
        128'({1'b1, 32'h100, 64'h4000_0000_0000_0000}));

    // Random wait states, stalls and redirects, some near the top of memory.
    max_delay = 5;
    for (int s = 0; s < 14; s++) begin
      logic [31:0] t;
      if (s % 3 == 1) t = 32'hFFFF_FFE0 + 32'($urandom_range(0, 7)) * 32'd4;
      else            t = $urandom() & 32'hFFFF_FFFC;
      @(posedge clk); #1;
      pc_set_i = 1'b1; pc_in = t; stall_i = ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
      pc_set_i = 1'b0; seg_id++; seg_pc = t;
      repeat ($urandom_range(40, 70)) begin
        stall_i = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
      end
    end

    // Reset and redirect together: reset wins.
    max_delay = 0; stall_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1; pc_set_i = 1'b1; pc_in = 32'h300;
    @(posedge clk); #1;
    rst_i = 1'b0; pc_set_i = 1'b0; seg_id++; seg_pc = 32'h0;
    @(negedge clk);
    chk("rst_prio", 0, 128'({g_inst[0].bus_cyc, g_inst[0].bus_adr}), 128'({1'b1, 32'h0}));
    repeat (20) @(posedge clk);

    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
